// File: rtl/writeback_arbiter.sv
// Arbitrates the register bank's single write port between the ALU and load
// writeback sources: memory first, with a starvation override for the ALU.
module writeback_arbiter #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 6,
  parameter int STARVE_LIMIT = 3,
  parameter int ZERO_REG     = 31
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [4:0]            alu_dest,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [4:0]            mem_dest,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [15:0]           collision_count
);

  localparam logic [0:0] MEM_PRI   = 1'b0;
  localparam logic [0:0] ALU_PRI   = 1'b1;
  localparam logic [3:0] WAIT_MAX  = 4'(STARVE_LIMIT);
  localparam logic [4:0] ZERO_DEST = 5'(ZERO_REG);

  function automatic logic [3:0] sat_wait_inc(input logic [3:0] v);
    return (v >= WAIT_MAX) ? WAIT_MAX : v + 4'd1;
  endfunction

  function automatic logic [15:0] sat_count_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [0:0]            state_q;
  logic [0:0]            state_next;
  logic [3:0]            alu_wait_q;
  logic [3:0]            alu_wait_next;
  logic [15:0]           collision_q;
  logic                  alu_grant;
  logic                  mem_grant;
  logic                  vld_p0;
  logic [4:0]            dest_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [DATA_WIDTH-1:0] data_p1;

  // Stage p0: combinational grant and source select
  always_comb begin
    alu_grant = 1'b0;
    mem_grant = 1'b0;
    if (!reset) begin
      if (state_q == ALU_PRI) begin
        if (alu_valid)      alu_grant = 1'b1;
        else if (mem_valid) mem_grant = 1'b1;
      end else begin
        if (mem_valid)      mem_grant = 1'b1;
        else if (alu_valid) alu_grant = 1'b1;
      end
    end
  end

  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;
  assign vld_p0    = alu_grant | mem_grant;
  assign dest_p0   = alu_grant ? alu_dest : mem_dest;
  assign data_p0   = alu_grant ? alu_data : mem_data;

  always_comb begin
    alu_wait_next = alu_wait_q;
    if (alu_grant)      alu_wait_next = 4'd0;
    else if (alu_valid) alu_wait_next = sat_wait_inc(alu_wait_q);
  end

  // Priority flips on the same edge the wait count reaches the limit, so the
  // ALU is granted in the very next cycle.
  always_comb begin
    state_next = state_q;
    if (state_q == ALU_PRI) begin
      if (alu_grant) state_next = MEM_PRI;
    end else if (alu_wait_next == WAIT_MAX) begin
      state_next = ALU_PRI;
    end
  end

  // Stage p1: registered bank write port and control state
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= MEM_PRI;
      alu_wait_q  <= 4'd0;
      collision_q <= 16'd0;
      vld_p1      <= 1'b0;
      addr_p1     <= '0;
      data_p1     <= '0;
    end else begin
      state_q    <= state_next;
      alu_wait_q <= alu_wait_next;
      if (alu_valid && mem_valid) collision_q <= sat_count_inc(collision_q);
      vld_p1 <= vld_p0 && (dest_p0 != ZERO_DEST);
      if (vld_p0 && (dest_p0 != ZERO_DEST)) begin
        addr_p1 <= {{(ADDR_WIDTH-5){1'b0}}, dest_p0};
        data_p1 <= data_p0;
      end
    end
  end

  assign write           = vld_p1;
  assign write_addr      = addr_p1;
  assign write_data      = data_p1;
  assign collision_count = collision_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: handshake, priority, starvation,
// zero-register discard, mid-stream reset and collision counter saturation.
module tb_writeback_arbiter;

  logic        clock;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [63:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [63:0] mem_data;
  logic        mem_ready;
  logic        write;
  logic [5:0]  write_addr;
  logic [63:0] write_data;
  logic [15:0] collision_count;

  int n_checks = 0;
  int n_errors = 0;
  int mk;

  writeback_arbiter #(
    .DATA_WIDTH(64), .ADDR_WIDTH(6), .STARVE_LIMIT(3), .ZERO_REG(31)
  ) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_dest(alu_dest), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_dest(mem_dest), .mem_data(mem_data), .mem_ready(mem_ready),
    .write(write), .write_addr(write_addr), .write_data(write_data),
    .collision_count(collision_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    alu_valid = 1'b1; alu_dest = 5'd1; alu_data = 64'd1;
    mem_valid = 1'b1; mem_dest = 5'd2; mem_data = 64'd2;
    #1;
    check_eq("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
    check_eq("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    check_eq("rst_write", {63'd0, write}, 64'd0);
    check_eq("rst_addr", {58'd0, write_addr}, 64'd0);
    check_eq("rst_data", write_data, 64'd0);
    check_eq("rst_count", {48'd0, collision_count}, 64'd0);

    // Single ALU request
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 64'h1234;
    #1;
    check_eq("t1_alu_ready", {63'd0, alu_ready}, 64'd1);
    check_eq("t1_mem_ready", {63'd0, mem_ready}, 64'd0);
    @(posedge clock); #1;
    alu_valid = 1'b0;
    check_eq("t1_write", {63'd0, write}, 64'd1);
    check_eq("t1_addr", {58'd0, write_addr}, 64'd5);
    check_eq("t1_data", write_data, 64'h1234);
    @(posedge clock); #1;
    check_eq("t1_idle_write", {63'd0, write}, 64'd0);
    check_eq("t1_idle_addr", {58'd0, write_addr}, 64'd5);

    // Both valid: memory first, then ALU
    mem_valid = 1'b1; mem_dest = 5'd3; mem_data = 64'hAAAA;
    alu_valid = 1'b1; alu_dest = 5'd4; alu_data = 64'hBBBB;
    #1;
    check_eq("t2_mem_ready", {63'd0, mem_ready}, 64'd1);
    check_eq("t2_alu_ready", {63'd0, alu_ready}, 64'd0);
    @(posedge clock); #1;
    mem_valid = 1'b0;
    check_eq("t2_addr_mem", {58'd0, write_addr}, 64'd3);
    check_eq("t2_data_mem", write_data, 64'hAAAA);
    #1;
    check_eq("t2_alu_ready2", {63'd0, alu_ready}, 64'd1);
    @(posedge clock); #1;
    alu_valid = 1'b0;
    check_eq("t2_addr_alu", {58'd0, write_addr}, 64'd4);
    check_eq("t2_data_alu", write_data, 64'hBBBB);
    check_eq("t2_count", {48'd0, collision_count}, 64'd1);

    // Starvation: M,M,M,A then memory resumes
    mk = 0;
    alu_valid = 1'b1; alu_dest = 5'd20; alu_data = 64'hA1A1;
    mem_valid = 1'b1; mem_dest = 5'd10; mem_data = 64'd100;
    for (int c = 0; c <= 10; c++) begin
      #1;
      check_eq($sformatf("t3_alu_ready_%0d", c), {63'd0, alu_ready}, (c == 3) ? 64'd1 : 64'd0);
      check_eq($sformatf("t3_mem_ready_%0d", c), {63'd0, mem_ready}, (c == 3) ? 64'd0 : 64'd1);
      @(posedge clock); #1;
      check_eq($sformatf("t3_write_%0d", c), {63'd0, write}, 64'd1);
      check_eq($sformatf("t3_addr_%0d", c), {58'd0, write_addr},
               (c == 3) ? 64'd20 : 64'(10 + mk));
      check_eq($sformatf("t3_data_%0d", c), write_data,
               (c == 3) ? 64'hA1A1 : 64'(100 + mk));
      if (c == 3) begin
        alu_valid = 1'b0;
      end else begin
        mk++;
        mem_dest = 5'(10 + mk);
        mem_data = 64'(100 + mk);
      end
    end
    mem_valid = 1'b0;
    check_eq("t3_count", {48'd0, collision_count}, 64'd5);

    // Zero register write is accepted but discarded
    mem_valid = 1'b1; mem_dest = 5'd31; mem_data = 64'hFFFF;
    #1;
    check_eq("t4_mem_ready", {63'd0, mem_ready}, 64'd1);
    @(posedge clock); #1;
    mem_valid = 1'b0;
    check_eq("t4_write", {63'd0, write}, 64'd0);
    check_eq("t4_addr_hold", {58'd0, write_addr}, 64'd19);
    check_eq("t4_data_hold", write_data, 64'd109);

    // Build alu_wait = 2, then reset on the would-be ALU grant cycle
    mem_valid = 1'b1; mem_dest = 5'd1; mem_data = 64'd11;
    alu_valid = 1'b1; alu_dest = 5'd2; alu_data = 64'd22;
    @(posedge clock); #1;
    mem_data = 64'd12;
    @(posedge clock); #1;
    check_eq("t5_pre_count", {48'd0, collision_count}, 64'd7);
    mem_valid = 1'b0; reset = 1'b1;
    #1;
    check_eq("t5_alu_ready_rst", {63'd0, alu_ready}, 64'd0);
    @(posedge clock); #1;
    check_eq("t5_write", {63'd0, write}, 64'd0);
    check_eq("t5_count", {48'd0, collision_count}, 64'd0);
    check_eq("t5_addr", {58'd0, write_addr}, 64'd0);
    reset = 1'b0;
    mem_valid = 1'b1; mem_dest = 5'd7; mem_data = 64'd77;
    for (int k = 0; k <= 3; k++) begin
      #1;
      check_eq($sformatf("t5_alu_ready_%0d", k), {63'd0, alu_ready}, (k == 3) ? 64'd1 : 64'd0);
      check_eq($sformatf("t5_mem_ready_%0d", k), {63'd0, mem_ready}, (k == 3) ? 64'd0 : 64'd1);
      @(posedge clock); #1;
      check_eq($sformatf("t5_addr_%0d", k), {58'd0, write_addr}, (k == 3) ? 64'd2 : 64'd7);
      if (k == 3) alu_valid = 1'b0;
    end
    check_eq("t5_count_after", {48'd0, collision_count}, 64'd4);

    // Collision counter saturation
    alu_valid = 1'b1;
    repeat (65530) @(posedge clock);
    #1;
    check_eq("t6_count_fffe", {48'd0, collision_count}, 64'hFFFE);
    @(posedge clock); #1;
    check_eq("t6_count_ffff", {48'd0, collision_count}, 64'hFFFF);
    repeat (4469) @(posedge clock);
    #1;
    check_eq("t6_count_sat", {48'd0, collision_count}, 64'hFFFF);
    alu_valid = 1'b0; mem_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
